pairing_loop_seq: RTL and testbench

- Parametrised control sequencer for the Tate pairing core.
- Drives the Miller-loop iteration (GF(3^m) multiplier, then GF(3^6m) multiplier/accumulator), then the final-exponentiation stage, and returns the result through a valid/ready handshake.
- Replaces the fixed one-hot iteration shifter and done-edge chaining with:
  - a counted loop of configurable length,
  - start/busy/abort control,
  - a per-wait watchdog,
  - an output hold.
- Datapath units stay external and are driven only through the reset/enable/done ports below.

---
 rtl/pairing_loop_seq.sv | 162 ++++++++++++++++
 tb/tb_pairing_loop_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pairing_loop_seq.sv
// Control sequencer for the Tate pairing core: counted Miller loop, final
// exponentiation and a held result handshake, with abort and a per-wait watchdog.
//
// state    | meaning                        state    | meaning
// IDLE     | waiting for start              UPDATE   | commit a,b,t,y; step d and index
// LOAD     | load operands                  FE_RST   | reset final-exponentiation unit
// MUL_RST  | hold GF(3^m) mults in reset    FE_WAIT  | wait for final exponentiation
// MUL_WAIT | wait for GF(3^m) mults         OUT      | result held until accepted
// EXT_RST  | reset GF(3^6m) multiplier      EXT_WAIT | wait for GF(3^6m) multiplier
module pairing_loop_seq #(
   parameter int ITER    = 97,
   parameter int CNT_W   = 7,
   parameter int RST_DLY = 2,
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             load_en,
   output logic             mul_rst,
   input  logic             mul_done,
   output logic             ext_rst,
   input  logic             ext_done,
   output logic             upd_en,
   output logic [1:0]       d,
   output logic [CNT_W-1:0] iter_idx,
   output logic             fe_rst,
   input  logic             fe_done,
   output logic             cap_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err
);

   localparam int DLY_W = (RST_DLY > 1) ? $clog2(RST_DLY) : 1;
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(ITER - 1);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RST_DLY - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_MUL_RST, S_MUL_WAIT, S_EXT_RST,
      S_EXT_WAIT, S_UPDATE, S_FE_RST, S_FE_WAIT, S_OUT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic [1:0]       d_q, d_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [TO_W-1:0]  wd_q, wd_d;
   logic             err_q, err_d;
   logic             mul_done_q, ext_done_q, fe_done_q;
   logic             mul_edge, ext_edge, fe_edge;
   logic             in_wait, wait_edge, wd_fire;

   assign mul_edge = mul_done & ~mul_done_q;
   assign ext_edge = ext_done & ~ext_done_q;
   assign fe_edge  = fe_done & ~fe_done_q;

   assign in_wait   = (state_q == S_MUL_WAIT) || (state_q == S_EXT_WAIT) || (state_q == S_FE_WAIT);
   assign wait_edge = ((state_q == S_MUL_WAIT) && mul_edge) ||
                      ((state_q == S_EXT_WAIT) && ext_edge) ||
                      ((state_q == S_FE_WAIT)  && fe_edge);
   assign wd_fire   = (TIMEOUT != 0) && in_wait && !wait_edge && (wd_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      d_d     = d_q;
      dly_d   = dly_q;
      err_d   = err_q;
      // Outside a wait the watchdog sits at zero, so every wait starts fresh.
      wd_d    = in_wait ? wd_q + 1'b1 : '0;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_d = S_LOAD;
                  err_d   = 1'b0;
               end
            end
            S_LOAD: begin
               iter_d  = '0;
               d_d     = 2'b01;
               dly_d   = DLY_LAST;
               state_d = S_MUL_RST;
            end
            S_MUL_RST: begin
               if (dly_q == '0) state_d = S_MUL_WAIT;
               else             dly_d   = dly_q - 1'b1;
            end
            S_MUL_WAIT: if (mul_edge) state_d = S_EXT_RST;
            S_EXT_RST:  state_d = S_EXT_WAIT;
            S_EXT_WAIT: if (ext_edge) state_d = S_UPDATE;
            S_UPDATE: begin
               case (d_q)
                  2'b01:   d_d = 2'b00;
                  2'b00:   d_d = 2'b10;
                  default: d_d = 2'b01;
               endcase
               dly_d = DLY_LAST;
               if (iter_q == IDX_LAST) begin
                  state_d = S_FE_RST;
               end else begin
                  iter_d  = iter_q + 1'b1;
                  state_d = S_MUL_RST;
               end
            end
            S_FE_RST:  state_d = S_FE_WAIT;
            S_FE_WAIT: if (fe_edge) state_d = S_OUT;
            S_OUT:     if (out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
         if (wd_fire) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         iter_q     <= '0;
         d_q        <= 2'b01;
         dly_q      <= '0;
         wd_q       <= '0;
         err_q      <= 1'b0;
         mul_done_q <= 1'b0;
         ext_done_q <= 1'b0;
         fe_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         iter_q     <= iter_d;
         d_q        <= d_d;
         dly_q      <= dly_d;
         wd_q       <= wd_d;
         err_q      <= err_d;
         mul_done_q <= mul_done;
         ext_done_q <= ext_done;
         fe_done_q  <= fe_done;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign load_en   = (state_q == S_LOAD);
   assign upd_en    = (state_q == S_UPDATE);
   assign mul_rst   = !((state_q == S_MUL_WAIT) || (state_q == S_EXT_RST) || (state_q == S_EXT_WAIT));
   assign ext_rst   = (state_q != S_EXT_WAIT);
   assign fe_rst    = !((state_q == S_FE_WAIT) || (state_q == S_OUT));
   assign out_valid = (state_q == S_OUT);
   // An abort landing on the final done edge must not capture a result.
   assign cap_en    = (state_q == S_FE_WAIT) && fe_edge && !abort;
   assign d         = d_q;
   assign iter_idx  = iter_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pairing_loop_seq.sv
// Bench for pairing_loop_seq: per-cycle expected output timelines built from
// the sequencing latencies, with randomized latencies, start noise, abort and stalls.
module tb_pairing_loop_seq;

   localparam int ITER_P    = 4;
   localparam int CNT_W_P   = 3;
   localparam int RST_DLY_P = 2;
   localparam int TIMEOUT_P = 8;
   localparam int TO_W_P    = 4;
   localparam int MAXC      = 256;

   logic               clk = 1'b0;
   logic               reset, start, abort, mul_done, ext_done, fe_done, out_ready;
   logic               busy, load_en, mul_rst, ext_rst, upd_en, fe_rst, cap_en, out_valid, err;
   logic [1:0]         d;
   logic [CNT_W_P-1:0] iter_idx;

   int n_chk = 0;
   int n_fail = 0;

   pairing_loop_seq #(
      .ITER(ITER_P), .CNT_W(CNT_W_P), .RST_DLY(RST_DLY_P), .TIMEOUT(TIMEOUT_P), .TO_W(TO_W_P)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy),
      .load_en(load_en), .mul_rst(mul_rst), .mul_done(mul_done), .ext_rst(ext_rst),
      .ext_done(ext_done), .upd_en(upd_en), .d(d), .iter_idx(iter_idx), .fe_rst(fe_rst),
      .fe_done(fe_done), .cap_en(cap_en), .out_valid(out_valid), .out_ready(out_ready),
      .err(err)
   );

   always #5 clk = ~clk;

   // run configuration
   int lm[ITER_P];
   int le[ITER_P];
   int lf, hold, abort_iter, stall_iter;
   bit pre_high;
   logic [1:0]         cur_d;
   logic [CNT_W_P-1:0] cur_idx;
   logic               cur_err;

   // expected timeline and input drive schedule
   logic e_busy[MAXC], e_load[MAXC], e_upd[MAXC], e_cap[MAXC], e_valid[MAXC];
   logic e_mrst[MAXC], e_erst[MAXC], e_frst[MAXC], e_err[MAXC];
   logic [1:0]         e_d[MAXC];
   logic [CNT_W_P-1:0] e_idx[MAXC];
   logic dr_mul[MAXC], dr_ext[MAXC], dr_fe[MAXC], dr_rdy[MAXC], dr_abort[MAXC];
   int n_cyc, kill;

   function automatic logic [1:0] d_of(input int k);
      case (k % 3)
         0:       return 2'b01;
         1:       return 2'b00;
         default: return 2'b10;
      endcase
   endfunction

   task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
      end
   endtask

   task automatic rnd_cfg();
      for (int i = 0; i < ITER_P; i++) begin
         lm[i] = $urandom_range(0, 6);
         le[i] = $urandom_range(0, 6);
      end
      lf = $urandom_range(0, 6);
      hold = $urandom_range(0, 3);
      abort_iter = -1;
      stall_iter = -1;
      pre_high = 0;
   endtask

   task automatic build();
      int c, w, ew, u, fw, cap, o, r, ab;
      bit stalled;
      stalled = 0;
      ab = -1;
      for (int t = 0; t < MAXC; t++) begin
         e_busy[t] = 1; e_load[t] = 0; e_upd[t] = 0; e_cap[t] = 0; e_valid[t] = 0;
         e_mrst[t] = 1; e_erst[t] = 1; e_frst[t] = 1; e_err[t] = 0;
         e_d[t] = cur_d; e_idx[t] = cur_idx;
         dr_mul[t] = 0; dr_ext[t] = 0; dr_fe[t] = 0; dr_rdy[t] = 0; dr_abort[t] = 0;
      end
      e_busy[0] = 0;
      e_err[0] = cur_err;
      e_load[1] = 1;
      c = 2;
      for (int i = 0; i < ITER_P; i++) begin
         w = c + RST_DLY_P;
         if (pre_high && i == 0)
            for (int t = c; t < w + 2; t++) dr_mul[t] = 1;
         if (i == stall_iter) begin
            kill = w + TIMEOUT_P;
            for (int t = c; t < kill; t++) begin e_d[t] = d_of(i); e_idx[t] = CNT_W_P'(i); end
            for (int t = w; t < kill; t++) e_mrst[t] = 0;
            stalled = 1;
            break;
         end
         ew = w + lm[i] + 2;
         u = ew + le[i] + 1;
         for (int t = c; t <= u; t++) begin e_d[t] = d_of(i); e_idx[t] = CNT_W_P'(i); end
         for (int t = w; t < u; t++) e_mrst[t] = 0;
         for (int t = ew; t < u; t++) e_erst[t] = 0;
         for (int t = w + lm[i]; t <= u; t++) dr_mul[t] = 1;
         for (int t = ew + le[i]; t <= u; t++) dr_ext[t] = 1;
         e_upd[u] = 1;
         if (i == abort_iter) ab = ew;
         c = u + 1;
      end
      if (!stalled) begin
         fw = c + 1;
         cap = fw + lf;
         o = cap + 1;
         r = o + hold;
         for (int t = c; t <= r; t++) begin e_d[t] = d_of(ITER_P); e_idx[t] = CNT_W_P'(ITER_P - 1); end
         for (int t = fw; t <= r; t++) e_frst[t] = 0;
         for (int t = cap; t <= r; t++) dr_fe[t] = 1;
         for (int t = o; t <= r; t++) e_valid[t] = 1;
         e_cap[cap] = 1;
         dr_rdy[r] = 1;
         kill = r + 1;
      end
      if (ab >= 0) begin
         dr_abort[ab] = 1;
         e_cap[ab] = 0;
         kill = ab + 1;
      end
      n_cyc = kill + 3;
      for (int t = kill; t < n_cyc; t++) begin
         e_busy[t] = 0; e_load[t] = 0; e_upd[t] = 0; e_cap[t] = 0; e_valid[t] = 0;
         e_mrst[t] = 1; e_erst[t] = 1; e_frst[t] = 1; e_err[t] = stalled;
         e_d[t] = e_d[kill - 1]; e_idx[t] = e_idx[kill - 1];
         dr_mul[t] = 0; dr_ext[t] = 0; dr_fe[t] = 0; dr_rdy[t] = 0;
      end
   endtask

   task automatic exec_run(input string name);
      int upd_obs, cap_obs, upd_exp, cap_exp;
      upd_obs = 0; cap_obs = 0; upd_exp = 0; cap_exp = 0;
      for (int c = 0; c < n_cyc; c++) begin
         @(posedge clk); #1;
         start = (c == 0) ? 1'b1 : ((c < kill) ? 1'($urandom_range(0, 1)) : 1'b0);
         abort = dr_abort[c];
         mul_done = dr_mul[c];
         ext_done = dr_ext[c];
         fe_done = dr_fe[c];
         out_ready = dr_rdy[c];
         @(negedge clk);
         chk({name, ".busy"}, c, 8'(busy), 8'(e_busy[c]));
         chk({name, ".load_en"}, c, 8'(load_en), 8'(e_load[c]));
         chk({name, ".upd_en"}, c, 8'(upd_en), 8'(e_upd[c]));
         chk({name, ".cap_en"}, c, 8'(cap_en), 8'(e_cap[c]));
         chk({name, ".out_valid"}, c, 8'(out_valid), 8'(e_valid[c]));
         chk({name, ".mul_rst"}, c, 8'(mul_rst), 8'(e_mrst[c]));
         chk({name, ".ext_rst"}, c, 8'(ext_rst), 8'(e_erst[c]));
         chk({name, ".fe_rst"}, c, 8'(fe_rst), 8'(e_frst[c]));
         chk({name, ".err"}, c, 8'(err), 8'(e_err[c]));
         chk({name, ".d"}, c, 8'(d), 8'(e_d[c]));
         chk({name, ".iter_idx"}, c, 8'(iter_idx), 8'(e_idx[c]));
         upd_obs += (upd_en === 1'b1) ? 1 : 0;
         cap_obs += (cap_en === 1'b1) ? 1 : 0;
         upd_exp += int'(e_upd[c]);
         cap_exp += int'(e_cap[c]);
      end
      chk({name, ".upd_count"}, n_cyc, 8'(upd_obs), 8'(upd_exp));
      chk({name, ".cap_count"}, n_cyc, 8'(cap_obs), 8'(cap_exp));
      cur_d = e_d[n_cyc - 1];
      cur_idx = e_idx[n_cyc - 1];
      cur_err = e_err[n_cyc - 1];
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, ".busy"}, 0, 8'(busy), 8'd0);
      chk({name, ".load_en"}, 0, 8'(load_en), 8'd0);
      chk({name, ".upd_en"}, 0, 8'(upd_en), 8'd0);
      chk({name, ".cap_en"}, 0, 8'(cap_en), 8'd0);
      chk({name, ".out_valid"}, 0, 8'(out_valid), 8'd0);
      chk({name, ".err"}, 0, 8'(err), 8'd0);
      chk({name, ".mul_rst"}, 0, 8'(mul_rst), 8'd1);
      chk({name, ".ext_rst"}, 0, 8'(ext_rst), 8'd1);
      chk({name, ".fe_rst"}, 0, 8'(fe_rst), 8'd1);
      chk({name, ".d"}, 0, 8'(d), 8'h01);
      chk({name, ".iter_idx"}, 0, 8'(iter_idx), 8'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      mul_done = 1'b0; ext_done = 1'b0; fe_done = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("por");
      @(posedge clk); #1;
      reset = 1'b0;
      cur_d = 2'b01; cur_idx = '0; cur_err = 1'b0;

      // directed latencies, result held for 10 cycles
      rnd_cfg();
      for (int i = 0; i < ITER_P; i++) begin lm[i] = 3; le[i] = 5; end
      lf = 4; hold = 10;
      build(); exec_run("directed");

      // done already high across MUL_RST must not count
      rnd_cfg(); pre_high = 1; lm[0] = $urandom_range(3, 6);
      build(); exec_run("prehigh");

      rnd_cfg(); abort_iter = 1;
      build(); exec_run("abort");

      rnd_cfg();
      build(); exec_run("after_abort");

      rnd_cfg(); stall_iter = 2;
      build(); exec_run("timeout");

      // abort in IDLE suppresses start; err stays set
      @(posedge clk); #1; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1; start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_idle.busy", 0, 8'(busy), 8'd0);
      chk("abort_idle.err", 0, 8'(err), 8'd1);

      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("idle_reset");
      cur_d = 2'b01; cur_idx = '0; cur_err = 1'b0;

      for (int k = 0; k < 3; k++) begin
         rnd_cfg();
         build(); exec_run("random");
      end

      // reset in the middle of a run
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("midrun.busy", 0, 8'(busy), 8'd1);
      chk("midrun.mul_rst", 0, 8'(mul_rst), 8'd0);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrun_reset");
      cur_d = 2'b01; cur_idx = '0; cur_err = 1'b0;

      rnd_cfg();
      build(); exec_run("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
